emac_rx_frame_buf: RTL and testbench
====================================

EMAC_RX_FRAME_BUF -- requirements
Module: emac_rx_frame_buf

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 11, setting byte RAM depth to 2^ADDR_W bytes.
REQ-002 The block SHALL have a parameter LEN_AW, default 4, setting length-FIFO depth to 2^LEN_AW frame entries.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock (MAC receive clock domain).
REQ-004 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port rx_data, input, 8 bits, received byte from the MAC receive stage.
REQ-006 The block SHALL have port rx_data_valid, input, 1 bit, rx_data qualifier.
REQ-007 The block SHALL have port rx_good_frame, input, 1 bit, one-cycle pulse: current frame passed CRC.
REQ-008 The block SHALL have port rx_bad_frame, input, 1 bit, one-cycle pulse: current frame failed.
REQ-009 The block SHALL have port out_data, output, 8 bits, buffered frame byte.
REQ-010 The block SHALL have port out_valid, output, 1 bit, out_data qualifier.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accepts the byte when out_valid is high.
REQ-012 The block SHALL have ports out_sof and out_eof, outputs, 1 bit each, marking the first and last byte of a frame.
REQ-013 The block SHALL have ports good_cnt, bad_cnt and drop_cnt, outputs, 16 bits each, frame statistics.

Function
REQ-014 Write side SHALL store each byte with rx_data_valid high at wr_ptr, increment wr_ptr modulo 2^ADDR_W, and increment frame length.
REQ-015 A byte coinciding with rx_good_frame or rx_bad_frame SHALL belong to the ending frame and be stored before the commit or rollback decision.
REQ-016 On rx_good_frame with nonzero length and no overflow, commit_ptr SHALL become wr_ptr and the length SHALL be pushed to the length FIFO in the same cycle.
REQ-017 On rx_bad_frame, wr_ptr SHALL roll back to commit_ptr and nothing SHALL be pushed.
REQ-018 Full condition: a write that would make wr_ptr equal rd_ptr SHALL mark the frame overflowed; further bytes of that frame are discarded.
REQ-019 An overflowed frame, or a good frame arriving while the length FIFO is full, SHALL be rolled back and counted in drop_cnt, not good_cnt.
REQ-020 rx_good_frame with zero stored bytes SHALL be ignored with no push and no count.
REQ-021 Read FSM states SHALL be IDLE, LOAD and SEND.
REQ-022 FSM transition IDLE->LOAD SHALL occur when the length FIFO is non-empty.
REQ-023 In LOAD, the FSM SHALL pop the length, issue the RAM read at rd_ptr and go to SEND.
REQ-024 In SEND, out_valid SHALL be high, and each transfer (out_valid and out_ready) SHALL advance rd_ptr and present the next byte with no bubble.
REQ-025 On the transfer with out_eof, the FSM SHALL go to LOAD if the length FIFO is non-empty, else IDLE.
REQ-026 out_data, out_sof and out_eof SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 out_sof and out_eof SHALL both be high for a 1-byte frame.
REQ-028 First-byte latency SHALL be 2 cycles from the commit cycle to out_valid high when the FSM is IDLE.
REQ-029 RAM space SHALL be freed only as rd_ptr advances, and all pointers SHALL wrap modulo 2^ADDR_W.
REQ-030 Commit and read in the same cycle SHALL both take effect.

Reset
REQ-031 rst_n low at a clock edge SHALL clear all pointers, lengths, counters and the length FIFO, and force the FSM to IDLE.
REQ-032 Reset SHALL force out_valid, out_sof, out_eof to 0 and out_data to 8'h00.
REQ-033 A frame in progress at reset SHALL be discarded, and write side SHALL ignore input until the next rx_good_frame/rx_bad_frame boundary.

Configuration
REQ-034 With RX_FRAME_STATS_EN defined, good_cnt, bad_cnt and drop_cnt SHALL count respective events and saturate at 16'hFFFF.
REQ-035 Without RX_FRAME_STATS_EN, the counters SHALL not be built and the three outputs SHALL be constant 0.

Verification
REQ-036 Bench SHALL cover: 64-byte frame 00..3F then rx_good_frame, out_ready=1 -> out_valid 2 cycles after the pulse, 64 bytes 00..3F, sof on 00, eof on 3F, good_cnt=1.
REQ-037 Bench SHALL cover: 60-byte frame then rx_bad_frame -> no output, wr_ptr back to commit_ptr, bad_cnt=1.
REQ-038 Bench SHALL cover: ADDR_W=6 with a 70-byte good frame -> dropped, drop_cnt=1, a following 10-byte frame is delivered intact.
REQ-039 Bench SHALL cover: 17 one-byte good frames, LEN_AW=4, out_ready=0 -> 16 queued, 17th dropped, then out_ready=1 -> 16 sof+eof bytes.
REQ-040 Bench SHALL cover: out_ready toggling every cycle during a 20-byte frame -> all bytes delivered once, in order, and stable while stalled.
REQ-041 Bench SHALL cover: rst_n low mid-frame (byte 30 of 64) then rx_good_frame -> nothing output, and the next frame is delivered.

Source files
------------

// File: rtl/emac_rx_frame_buf.sv
// Receive frame buffer: stores MAC receive bytes in a circular RAM and
// replays only frames that ended with a good-CRC pulse.
// Bad, overflowed or unqueueable frames are rolled back before the reader sees them.
// Optional build macro RX_FRAME_STATS_EN enables saturating good/bad/drop counters.
module emac_rx_frame_buf #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LEN_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  input  logic        rx_good_frame,
  input  logic        rx_bad_frame,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned LEN_DEPTH = 1 << LEN_AW;
  localparam int unsigned CNT_W     = LEN_AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  logic [7:0]        mem     [DEPTH];
  logic [ADDR_W-1:0] len_mem [LEN_DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] commit_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] frame_len;
  logic [ADDR_W-1:0] remain;
  logic              ovf;
  logic              hunt;
  logic [LEN_AW-1:0] lf_wr;
  logic [LEN_AW-1:0] lf_rd;
  logic [CNT_W-1:0]  lf_cnt;
  state_t            state;

  logic              wr_full_c;
  logic              wr_en_c;
  logic              ovf_now_c;
  logic [ADDR_W-1:0] len_now_c;
  logic [ADDR_W-1:0] wr_ptr_now_c;
  logic [ADDR_W-1:0] rd_nxt_c;
  logic              lf_full_c;
  logic              good_c;
  logic              bad_c;
  logic              push_c;
  logic              pop_c;
  logic              xfer_c;
  logic              lf_avail_c;

  // Write-side decode; the frame being delivered keeps its length slot until its last byte leaves
  always_comb begin
    wr_full_c    = (wr_ptr + ADDR_W'(1)) == rd_ptr;
    wr_en_c      = rx_data_valid && !hunt && !ovf && !wr_full_c;
    ovf_now_c    = ovf || (rx_data_valid && !hunt && !ovf && wr_full_c);
    len_now_c    = frame_len + ADDR_W'(wr_en_c);
    wr_ptr_now_c = wr_ptr + ADDR_W'(wr_en_c);
    rd_nxt_c     = rd_ptr + ADDR_W'(1);
    lf_full_c    = (lf_cnt + CNT_W'(state == SEND)) == CNT_W'(LEN_DEPTH);
    bad_c        = rx_bad_frame && !hunt;
    good_c       = rx_good_frame && !rx_bad_frame && !hunt;
    push_c       = good_c && !ovf_now_c && (len_now_c != '0) && !lf_full_c;
    pop_c        = (state == LOAD);
    xfer_c       = out_valid && out_ready;
    lf_avail_c   = (lf_cnt != '0) || push_c;
  end

  // Frame write pointer, commit and rollback; after reset wait for a frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_len  <= '0;
      ovf        <= 1'b0;
      hunt       <= 1'b1;
    end else if (hunt) begin
      if (rx_good_frame || rx_bad_frame) hunt <= 1'b0;
    end else if (bad_c || good_c) begin
      frame_len <= '0;
      ovf       <= 1'b0;
      if (push_c) begin
        commit_ptr <= wr_ptr_now_c;
        wr_ptr     <= wr_ptr_now_c;
      end else begin
        wr_ptr <= commit_ptr;
      end
    end else begin
      wr_ptr    <= wr_ptr_now_c;
      frame_len <= len_now_c;
      ovf       <= ovf_now_c;
    end
  end

  // Byte RAM write port
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_c) mem[wr_ptr] <= rx_data;
  end

  // Length FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) len_mem[lf_wr] <= len_now_c;
  end

  // Length FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lf_wr  <= '0;
      lf_rd  <= '0;
      lf_cnt <= '0;
    end else begin
      if (push_c) lf_wr <= lf_wr + LEN_AW'(1);
      if (pop_c)  lf_rd <= lf_rd + LEN_AW'(1);
      lf_cnt <= lf_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Read FSM: load a frame length, then stream bytes with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      remain    <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lf_avail_c) state <= LOAD;
        end
        LOAD: begin
          remain    <= len_mem[lf_rd];
          out_data  <= mem[rd_ptr];
          out_valid <= 1'b1;
          out_sof   <= 1'b1;
          out_eof   <= (len_mem[lf_rd] == ADDR_W'(1));
          state     <= SEND;
        end
        SEND: begin
          if (xfer_c) begin
            rd_ptr <= rd_nxt_c;
            if (out_eof) begin
              out_valid <= 1'b0;
              out_sof   <= 1'b0;
              out_eof   <= 1'b0;
              state     <= lf_avail_c ? LOAD : IDLE;
            end else begin
              out_data <= mem[rd_nxt_c];
              out_sof  <= 1'b0;
              out_eof  <= (remain == ADDR_W'(2));
              remain   <= remain - ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_FRAME_STATS_EN
  logic drop_c;
  assign drop_c = good_c && (ovf_now_c || ((len_now_c != '0) && lf_full_c));

  // Saturating frame statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      good_cnt <= 16'h0000;
      bad_cnt  <= 16'h0000;
      drop_cnt <= 16'h0000;
    end else begin
      if (push_c && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
      if (bad_c  && (bad_cnt  != 16'hFFFF)) bad_cnt  <= bad_cnt  + 16'd1;
      if (drop_c && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign good_cnt = 16'h0000;
  assign bad_cnt  = 16'h0000;
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_emac_rx_frame_buf.sv
// Bench for emac_rx_frame_buf: two instances (default size and a 64-byte RAM)
// share one stimulus stream; a frame-level model predicts delivered bytes and counters.
// Counter expectations follow RX_FRAME_STATS_EN (zero when the macro is undefined).
module tb_emac_rx_frame_buf;

`ifdef RX_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int LEN_DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_good_frame;
  logic       rx_bad_frame;
  logic       out_ready;

  logic [7:0]  o_data  [2];
  logic        o_valid [2];
  logic        o_sof   [2];
  logic        o_eof   [2];
  logic [15:0] g_cnt   [2];
  logic [15:0] b_cnt   [2];
  logic [15:0] d_cnt   [2];

  emac_rx_frame_buf dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_sof(o_sof[0]), .out_eof(o_eof[0]),
    .good_cnt(g_cnt[0]), .bad_cnt(b_cnt[0]), .drop_cnt(d_cnt[0])
  );

  emac_rx_frame_buf #(.ADDR_W(6), .LEN_AW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_sof(o_sof[1]), .out_eof(o_eof[1]),
    .good_cnt(g_cnt[1]), .bad_cnt(b_cnt[1]), .drop_cnt(d_cnt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: expected output entries are {sof, eof, data}
  logic [9:0] exp_q [2][$];
  logic [7:0] cur_q [2][$];
  bit         m_ovf [2];
  bit         m_hunt [2];
  int         fo [2];
  int         e_good [2];
  int         e_bad [2];
  int         e_drop [2];
  bit         prev_stall [2];
  bit         prev_mid [2];
  logic [7:0] prev_data [2];
  logic       prev_sof [2];
  logic       prev_eof [2];

  int n_vec;
  int n_err;
  bit toggle;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One model cycle, evaluated just before the posedge that consumes the current inputs
  task automatic model_cycle();
    int         occ;
    int         nfo;
    int         dep;
    logic [9:0] e;
    logic       xfer;
    for (int k = 0; k < 2; k++) begin
      dep = (k == 0) ? 2048 : 64;
      if (!rst_n) begin
        exp_q[k].delete();
        cur_q[k].delete();
        m_ovf[k] = 1'b0;
        m_hunt[k] = 1'b1;
        fo[k] = 0;
        e_good[k] = 0;
        e_bad[k] = 0;
        e_drop[k] = 0;
        prev_stall[k] = 1'b0;
        prev_mid[k] = 1'b0;
      end else begin
        chk("good_cnt", k, 32'(g_cnt[k]), 32'(STATS ? e_good[k] : 0));
        chk("bad_cnt",  k, 32'(b_cnt[k]), 32'(STATS ? e_bad[k]  : 0));
        chk("drop_cnt", k, 32'(d_cnt[k]), 32'(STATS ? e_drop[k] : 0));
        if (prev_stall[k]) begin
          chk("stall_valid", k, 32'(o_valid[k]), 32'd1);
          chk("stall_data",  k, 32'(o_data[k]),  32'(prev_data[k]));
          chk("stall_sof",   k, 32'(o_sof[k]),   32'(prev_sof[k]));
          chk("stall_eof",   k, 32'(o_eof[k]),   32'(prev_eof[k]));
        end
        if (prev_mid[k]) chk("no_bubble", k, 32'(o_valid[k]), 32'd1);
        chk("spurious_valid", k, 32'(o_valid[k] && (exp_q[k].size() == 0)), 32'd0);

        occ = exp_q[k].size() + cur_q[k].size();
        nfo = fo[k];
        xfer = o_valid[k] && out_ready;
        prev_mid[k] = 1'b0;
        if (xfer && (exp_q[k].size() != 0)) begin
          e = exp_q[k].pop_front();
          chk("out_data", k, 32'(o_data[k]), 32'(e[7:0]));
          chk("out_sof",  k, 32'(o_sof[k]),  32'(e[9]));
          chk("out_eof",  k, 32'(o_eof[k]),  32'(e[8]));
          if (e[8]) fo[k]--;
          else prev_mid[k] = 1'b1;
        end
        prev_stall[k] = o_valid[k] && !out_ready;
        prev_data[k] = o_data[k];
        prev_sof[k] = o_sof[k];
        prev_eof[k] = o_eof[k];

        if (m_hunt[k]) begin
          if (rx_good_frame || rx_bad_frame) m_hunt[k] = 1'b0;
        end else begin
          if (rx_data_valid && !m_ovf[k]) begin
            if (occ + 1 >= dep) m_ovf[k] = 1'b1;
            else cur_q[k].push_back(rx_data);
          end
          if (rx_bad_frame) begin
            e_bad[k] = sat16(e_bad[k]);
            cur_q[k].delete();
            m_ovf[k] = 1'b0;
          end else if (rx_good_frame) begin
            if (m_ovf[k]) begin
              e_drop[k] = sat16(e_drop[k]);
            end else if (cur_q[k].size() != 0) begin
              if (nfo >= LEN_DEPTH) begin
                e_drop[k] = sat16(e_drop[k]);
              end else begin
                for (int i = 0; i < cur_q[k].size(); i++)
                  exp_q[k].push_back({(i == 0), (i == cur_q[k].size() - 1), cur_q[k][i]});
                fo[k]++;
                e_good[k] = sat16(e_good[k]);
              end
            end
            cur_q[k].delete();
            m_ovf[k] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (toggle) out_ready = !out_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    rx_bad_frame = 1'b1;
    step();
    rx_bad_frame = 1'b0;
    step();
  endtask

  task automatic send_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      rx_data = 8'(base + i);
      rx_data_valid = 1'b1;
      step();
    end
    rx_data_valid = 1'b0;
  endtask

  task automatic pulse(input bit good);
    rx_good_frame = good;
    rx_bad_frame = !good;
    step();
    rx_good_frame = 1'b0;
    rx_bad_frame = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (((exp_q[0].size() != 0) || (exp_q[1].size() != 0)) && (n < budget)) begin
      step();
      n++;
    end
    chk("drain_left", 0, 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    toggle = 1'b0;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    rx_good_frame = 1'b0;
    rx_bad_frame = 1'b0;
    out_ready = 1'b1;

    // Reset state
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(o_valid[k]), 32'd0);
      chk("rst_data",  k, 32'(o_data[k]),  32'd0);
      chk("rst_sof",   k, 32'(o_sof[k]),   32'd0);
      chk("rst_eof",   k, 32'(o_eof[k]),   32'd0);
    end

    // 64-byte good frame, two-cycle first-byte latency
    send_bytes(64, 0);
    pulse(1'b1);
    chk("lat_valid_early", 0, 32'(o_valid[0]), 32'd0);
    step();
    chk("lat_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("lat_data",  0, 32'(o_data[0]),  32'h00);
    chk("lat_sof",   0, 32'(o_sof[0]),   32'd1);
    drain(200);
    chk("t64_good", 0, 32'(g_cnt[0]), 32'(STATS ? 1 : 0));
    chk("t64_drop_small", 1, 32'(d_cnt[1]), 32'(STATS ? 1 : 0));

    // 60-byte bad frame: nothing delivered
    do_reset();
    send_bytes(60, 8'h10);
    pulse(1'b0);
    for (int i = 0; i < 8; i++) step();
    chk("bad_valid", 0, 32'(o_valid[0]), 32'd0);
    chk("bad_cnt0",  0, 32'(b_cnt[0]), 32'(STATS ? 1 : 0));
    chk("bad_cnt1",  1, 32'(b_cnt[1]), 32'(STATS ? 1 : 0));

    // 70-byte frame overflows the small RAM, next 10-byte frame intact
    send_bytes(10, 8'h60);
    pulse(1'b1);
    drain(100);
    do_reset();
    send_bytes(70, 8'h20);
    pulse(1'b1);
    send_bytes(10, 8'h50);
    pulse(1'b1);
    drain(300);
    chk("ovf_drop", 1, 32'(d_cnt[1]), 32'(STATS ? 1 : 0));
    chk("ovf_good", 1, 32'(g_cnt[1]), 32'(STATS ? 1 : 0));

    // 17 one-byte frames while stalled: 16 queued, 17th dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'(i);
      rx_data_valid = 1'b1;
      rx_good_frame = 1'b1;
      step();
    end
    rx_data_valid = 1'b0;
    rx_good_frame = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("q_good", 0, 32'(g_cnt[0]), 32'(STATS ? 16 : 0));
    chk("q_drop", 0, 32'(d_cnt[0]), 32'(STATS ? 1 : 0));
    chk("q_head_data", 0, 32'(o_data[0]), 32'h00);
    chk("q_head_sof",  0, 32'(o_sof[0]),  32'd1);
    chk("q_head_eof",  0, 32'(o_eof[0]),  32'd1);
    out_ready = 1'b1;
    drain(200);

    // 20-byte frame with out_ready toggling every cycle
    do_reset();
    toggle = 1'b1;
    send_bytes(20, 8'h80);
    pulse(1'b1);
    drain(200);
    toggle = 1'b0;
    out_ready = 1'b1;

    // Reset mid-frame: remainder and its good pulse ignored, next frame delivered
    do_reset();
    send_bytes(30, 8'h00);
    rst_n = 1'b0;
    send_bytes(2, 8'h1E);
    rst_n = 1'b1;
    send_bytes(32, 8'h20);
    pulse(1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("rst_mid_valid", 0, 32'(o_valid[0]), 32'd0);
    chk("rst_mid_good",  0, 32'(g_cnt[0]), 32'd0);
    send_bytes(12, 8'hA0);
    pulse(1'b1);
    drain(100);
    chk("rst_next_good", 0, 32'(g_cnt[0]), 32'(STATS ? 1 : 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
